// File: rtl/rvfi_commit_packer.sv
// RVFI producer: turns per-port commit/exception events at the commit stage into
// registered rvfi_instr_t records, numbering retirements and flagging out-of-order acks.

package riscv;
  localparam int unsigned XLEN = 64;
  localparam int unsigned VLEN = 64;
endpackage

package rvfi_pkg;
  typedef struct packed {
    logic                      valid;
    logic [63:0]               order;
    logic [31:0]               insn;
    logic                      trap;
    logic                      halt;
    logic                      intr;
    logic [1:0]                mode;
    logic [1:0]                ixl;
    logic [4:0]                rs1_addr;
    logic [4:0]                rs2_addr;
    logic [riscv::XLEN-1:0]    rs1_rdata;
    logic [riscv::XLEN-1:0]    rs2_rdata;
    logic [4:0]                rd_addr;
    logic [riscv::XLEN-1:0]    rd_wdata;
    logic [riscv::VLEN-1:0]    pc_rdata;
    logic [riscv::VLEN-1:0]    pc_wdata;
    logic [riscv::VLEN-1:0]    mem_addr;
    logic [riscv::XLEN/8-1:0]  mem_rmask;
    logic [riscv::XLEN/8-1:0]  mem_wmask;
    logic [riscv::XLEN-1:0]    mem_rdata;
    logic [riscv::XLEN-1:0]    mem_wdata;
  } rvfi_instr_t;
endpackage

// Each rvfi_o[i] record is a one-cycle pulse qualified by its valid or trap bit;
// there is no ready signal, so the consumer must take every record it is shown.
module rvfi_commit_packer #(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int ORDER_W         = 64  // at most 64, the width of the order field
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NR_COMMIT_PORTS-1:0]                    commit_ack_i,
  input  logic [NR_COMMIT_PORTS-1:0][riscv::VLEN-1:0]   commit_pc_i,
  input  logic [NR_COMMIT_PORTS-1:0][31:0]              commit_insn_i,
  input  logic [NR_COMMIT_PORTS-1:0][4:0]               commit_rd_addr_i,
  input  logic [NR_COMMIT_PORTS-1:0]                    commit_rd_fp_i,
  input  logic [NR_COMMIT_PORTS-1:0][riscv::XLEN-1:0]   commit_rd_wdata_i,
  input  logic                                          ex_valid_i,
  input  logic [1:0]                                    priv_lvl_i,
  input  logic                                          flush_i,
  output rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0]   rvfi_o,
  output logic                                          order_err_o
);

  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_d, rvfi_q;
  logic [ORDER_W-1:0]                          order_d, order_q;
  logic                                        order_err_d, order_err_q;
  logic [NR_COMMIT_PORTS-1:0]                  slot_valid, slot_trap;

  // Exceptions are always charged to port 0 and squash every younger port.
  always_comb begin
    slot_valid    = '0;
    slot_trap     = '0;
    slot_trap[0]  = ex_valid_i;
    slot_valid[0] = commit_ack_i[0] & ~ex_valid_i;
    for (int i = 1; i < NR_COMMIT_PORTS; i++) begin
      slot_valid[i] = commit_ack_i[i] & ~ex_valid_i & ~flush_i;
    end
  end

  always_comb begin
    rvfi_d      = '0;
    order_d     = order_q;
    order_err_d = order_err_q;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      if (slot_valid[i] || slot_trap[i]) begin
        rvfi_d[i].valid    = slot_valid[i];
        rvfi_d[i].trap     = slot_trap[i];
        rvfi_d[i].order    = 64'(order_d);
        rvfi_d[i].insn     = commit_insn_i[i];
        rvfi_d[i].mode     = priv_lvl_i;
        rvfi_d[i].pc_rdata = commit_pc_i[i];
        // x0 writes are reported as zero; f0 is a real register and keeps its data.
        if (!slot_trap[i]) begin
          rvfi_d[i].rd_addr = commit_rd_addr_i[i];
          if (commit_rd_addr_i[i] != 5'd0 || commit_rd_fp_i[i]) begin
            rvfi_d[i].rd_wdata = commit_rd_wdata_i[i];
          end
        end
        order_d = order_d + ORDER_W'(1);
      end
    end
    for (int i = 1; i < NR_COMMIT_PORTS; i++) begin
      if (commit_ack_i[i] && !commit_ack_i[0]) begin
        order_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvfi_q      <= '0;
      order_q     <= '0;
      order_err_q <= 1'b0;
    end else begin
      rvfi_q      <= rvfi_d;
      order_q     <= order_d;
      order_err_q <= order_err_d;
    end
  end

  assign rvfi_o      = rvfi_q;
  assign order_err_o = order_err_q;

endmodule

// File: tb/tb_rvfi_commit_packer.sv
// Directed bench for rvfi_commit_packer: a vector table for single-cycle behaviour
// plus hand sequences for record clearing and asynchronous reset mid-stream.
module tb_rvfi_commit_packer;

  typedef rvfi_pkg::rvfi_instr_t rec_t;

  typedef struct {
    logic [1:0]  ack;
    logic        ex;
    logic        flush;
    logic [1:0]  fp;
    logic [1:0]  priv;
    logic [4:0]  rd0;
    logic [4:0]  rd1;
    logic [63:0] wd0;
    logic [63:0] wd1;
    logic        ev0;
    logic        et0;
    logic [63:0] eo0;
    logic [4:0]  erd0;
    logic [63:0] ewd0;
    logic        ev1;
    logic [63:0] eo1;
    logic [4:0]  erd1;
    logic [63:0] ewd1;
    logic        eerr;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic [1:0]        ack;
  logic [1:0][63:0]  pc;
  logic [1:0][31:0]  insn;
  logic [1:0][4:0]   rd_addr;
  logic [1:0]        rd_fp;
  logic [1:0][63:0]  rd_wdata;
  logic              ex_valid;
  logic [1:0]        priv;
  logic              flush;
  rec_t [1:0]        rvfi;
  rec_t [1:0]        rvfi_w;
  logic              err;
  logic              err_w;

  int total;
  int bad;
  vec_t vecs[12];

  rvfi_commit_packer #(.NR_COMMIT_PORTS(2), .ORDER_W(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .commit_ack_i(ack), .commit_pc_i(pc),
    .commit_insn_i(insn), .commit_rd_addr_i(rd_addr), .commit_rd_fp_i(rd_fp),
    .commit_rd_wdata_i(rd_wdata), .ex_valid_i(ex_valid), .priv_lvl_i(priv),
    .flush_i(flush), .rvfi_o(rvfi), .order_err_o(err)
  );

  // ORDER_W=2 copy on the same inputs: its counter wraps after four retirements.
  rvfi_commit_packer #(.NR_COMMIT_PORTS(2), .ORDER_W(2)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .commit_ack_i(ack), .commit_pc_i(pc),
    .commit_insn_i(insn), .commit_rd_addr_i(rd_addr), .commit_rd_fp_i(rd_fp),
    .commit_rd_wdata_i(rd_wdata), .ex_valid_i(ex_valid), .priv_lvl_i(priv),
    .flush_i(flush), .rvfi_o(rvfi_w), .order_err_o(err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t mk(input logic v, input logic t, input logic [63:0] o,
                              input logic [31:0] ins, input logic [63:0] p,
                              input logic [1:0] m, input logic [4:0] rd,
                              input logic [63:0] wd);
    rec_t r;
    r = '0;
    if (v || t) begin
      r.valid    = v;
      r.trap     = t;
      r.order    = o;
      r.insn     = ins;
      r.pc_rdata = p;
      r.mode     = m;
      r.rd_addr  = rd;
      r.rd_wdata = wd;
    end
    return r;
  endfunction

  task automatic chk_rec(input string nm, input rec_t act, input rec_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got v=%0b t=%0b ord=%0h pc=%0h rd=%0d wd=%0h want v=%0b t=%0b ord=%0h pc=%0h rd=%0d wd=%0h",
               nm, act.valid, act.trap, act.order, act.pc_rdata, act.rd_addr, act.rd_wdata,
               exp.valid, exp.trap, exp.order, exp.pc_rdata, exp.rd_addr, exp.rd_wdata);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    ack = 2'b00; ex_valid = 1'b0; flush = 1'b0; priv = 2'd3; rd_fp = 2'b00;
    pc = '0; insn = '0; rd_addr = '0; rd_wdata = '0;
  endtask

  task automatic drive_vec(input int i, input vec_t v);
    ack         = v.ack;
    ex_valid    = v.ex;
    flush       = v.flush;
    rd_fp       = v.fp;
    priv        = v.priv;
    pc[0]       = 64'h8000_0000 + 64'(8 * i);
    pc[1]       = 64'h8000_0004 + 64'(8 * i);
    insn[0]     = 32'h0000_0013 | (32'(i) << 20);
    insn[1]     = 32'h0010_0093 | (32'(i) << 20);
    rd_addr[0]  = v.rd0;
    rd_addr[1]  = v.rd1;
    rd_wdata[0] = v.wd0;
    rd_wdata[1] = v.wd1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //          ack    ex fl fp     pv rd0 rd1 wd0      wd1       ev0 et0 eo0 erd0 ewd0    ev1 eo1 erd1 ewd1    err
    vecs[0]  = '{2'b11, 0, 0, 2'b00, 3, 5, 1, 'h11,    'h22,     1, 0, 0,  5, 'h11,    1, 1,  1, 'h22,    0};
    vecs[1]  = '{2'b00, 0, 0, 2'b00, 3, 5, 1, 'h11,    'h22,     0, 0, 0,  0, 0,       0, 0,  0, 0,       0};
    vecs[2]  = '{2'b01, 0, 0, 2'b00, 3, 0, 1, 'hDEAD,  'h22,     1, 0, 2,  0, 0,       0, 0,  0, 0,       0};
    vecs[3]  = '{2'b01, 0, 0, 2'b01, 3, 0, 1, 'hDEAD,  'h22,     1, 0, 3,  0, 'hDEAD,  0, 0,  0, 0,       0};
    vecs[4]  = '{2'b01, 0, 0, 2'b00, 3, 7, 1, 'h77,    'h22,     1, 0, 4,  7, 'h77,    0, 0,  0, 0,       0};
    vecs[5]  = '{2'b11, 1, 0, 2'b00, 3, 9, 2, 'h99,    'h22,     0, 1, 5,  0, 0,       0, 0,  0, 0,       0};
    vecs[6]  = '{2'b11, 0, 1, 2'b00, 3, 3, 4, 'h33,    'h44,     1, 0, 6,  3, 'h33,    0, 0,  0, 0,       0};
    vecs[7]  = '{2'b00, 1, 0, 2'b00, 1, 8, 4, 'h88,    'h44,     0, 1, 7,  0, 0,       0, 0,  0, 0,       0};
    vecs[8]  = '{2'b11, 0, 0, 2'b00, 3, 2, 0, 'h20,    'hBEEF,   1, 0, 8,  2, 'h20,    1, 9,  0, 0,       0};
    vecs[9]  = '{2'b10, 0, 0, 2'b00, 3, 2, 6, 'h20,    'h66,     0, 0, 0,  0, 0,       1, 10, 6, 'h66,    1};
    vecs[10] = '{2'b11, 0, 0, 2'b10, 0, 4, 0, 'h40,    'hF0,     1, 0, 11, 4, 'h40,    1, 12, 0, 'hF0,    1};
    vecs[11] = '{2'b01, 0, 0, 2'b00, 3, 1, 1, 'h10,    'h11,     1, 0, 13, 1, 'h10,    0, 0,  0, 0,       1};

    rst_n = 1'b0;
    drive_idle();
    #12;
    chk_rec("reset_rec0", rvfi[0], '0);
    chk_rec("reset_rec1", rvfi[1], '0);
    chk_bit("reset_err", err, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      vec_t v;
      rec_t e0, e1;
      v = vecs[i];
      drive_vec(i, v);
      e0 = mk(v.ev0, v.et0, v.eo0, insn[0], pc[0], v.priv, v.erd0, v.ewd0);
      e1 = mk(v.ev1, 1'b0, v.eo1, insn[1], pc[1], v.priv, v.erd1, v.ewd1);
      @(posedge clk);
      @(negedge clk);
      chk_rec($sformatf("vec%0d_p0", i), rvfi[0], e0);
      chk_rec($sformatf("vec%0d_p1", i), rvfi[1], e1);
      chk_bit($sformatf("vec%0d_err", i), err, v.eerr);
      e0.order = v.eo0 & 64'd3;
      e1.order = v.eo1 & 64'd3;
      chk_rec($sformatf("vec%0d_wrap_p0", i), rvfi_w[0], e0);
      chk_rec($sformatf("vec%0d_wrap_p1", i), rvfi_w[1], e1);
    end

    // A record lasts one cycle and then clears, sticky error stays set.
    drive_idle();
    ack = 2'b11; pc[0] = 64'h9000_0000; pc[1] = 64'h9000_0004; rd_addr[0] = 5'd3; rd_addr[1] = 5'd4;
    rd_wdata[0] = 64'h30; rd_wdata[1] = 64'h40;
    @(posedge clk);
    @(negedge clk);
    chk_rec("pair_p0", rvfi[0], mk(1'b1, 1'b0, 64'd14, 32'd0, 64'h9000_0000, 2'd3, 5'd3, 64'h30));
    chk_rec("pair_p1", rvfi[1], mk(1'b1, 1'b0, 64'd15, 32'd0, 64'h9000_0004, 2'd3, 5'd4, 64'h40));
    drive_idle();
    @(posedge clk);
    @(negedge clk);
    chk_rec("cleared_p0", rvfi[0], '0);
    chk_rec("cleared_p1", rvfi[1], '0);
    chk_bit("err_sticky", err, 1'b1);

    // Asynchronous reset in the middle of a burst, with no clock edge.
    ack = 2'b11; pc[0] = 64'hA000_0000; pc[1] = 64'hA000_0004;
    @(posedge clk);
    #2;
    chk_bit("burst_valid_before_rst", rvfi[0].valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_rec("async_rst_p0", rvfi[0], '0);
    chk_rec("async_rst_p1", rvfi[1], '0);
    chk_bit("async_rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    ack = 2'b01; pc[0] = 64'hB000_0000; rd_addr[0] = 5'd1; rd_wdata[0] = 64'h5;
    @(posedge clk);
    @(negedge clk);
    chk_rec("post_rst_order0", rvfi[0], mk(1'b1, 1'b0, 64'd0, 32'd0, 64'hB000_0000, 2'd3, 5'd1, 64'h5));
    chk_rec("post_rst_p1", rvfi[1], '0);
    chk_bit("post_rst_err", err, 1'b0);
    drive_idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
